// File: rtl/uart_rx_if.sv
// Receive-side result bundle of the UART receiver: the recovered byte and its status.
// data_valid is a one-cycle strobe with no backpressure; data_out, frame_err and parity_err
// qualify it and hold their values until the next strobe. busy is a level, not part of the strobe.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (output data_out, output data_valid, output frame_err,
                  output parity_err, output busy);
  modport slave  (input data_out, input data_valid, input frame_err,
                  input parity_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1, LSB first); define UART_RX_PARITY_EN for an even-parity bit.
// state exposes the FSM encoding (IDLE = 0) for observation.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_tick,
  input  logic         rx,
  uart_rx_if.master    bus,
  output logic [2:0]   state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            done;
  logic [7:0]      data_q;
  logic            dv_q, fe_q;

`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d, pe_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid start bit: a high line here means a glitch, not a frame.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      // The strobe drops on the next clock even when no tick arrives.
      dv_q    <= 1'b0;
      if (sample_tick) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        sh_q    <= sh_d;
`ifdef UART_RX_PARITY_EN
        par_q   <= par_d;
`endif
        if (done) begin
          data_q <= sh_q;
          fe_q   <= ~rx_s;
          dv_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
          pe_q   <= ^{sh_q, par_q};
`endif
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected {parity_err, frame_err, byte}
// tuples are queued by the stimulus and matched against every data_valid strobe.
module tb_uart_rx;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Ticks from start detection to the stop-bit sample.
  localparam int F_TICKS = OS / 2 + (FRAME_BITS - 1) * OS;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick = 1'b0;
  logic       rx;
  logic [2:0] state;
  int         tick_div = 1;

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .bus         (bus),
    .state       (state)
  );

  // clock / tick generation
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_div == 1) sample_tick = 1'b1;
    else               sample_tick = ~sample_tick;
  end

  // scoreboard state
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int dv_count = 0;
  int dv_double = 0;
  int spurious = 0;
  int n_sent = 0;
  int cyc = 0;
  int last_dv_cyc = 0;
  int prev_dv_cyc = 0;
  logic       dv_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: match strobes against the queue, watch strobe width and data_out stability
  always @(posedge clk) begin
    #1;
    if (bus.data_valid === 1'b1) begin
      dv_count++;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc;
      if (dv_prev) dv_double++;
      if (exp_q.size() == 0) begin
        check("dv_unexpected", 32'(bus.data_valid), 0);
      end else begin
        check("frame", 32'({bus.parity_err, bus.frame_err, bus.data_out}),
              32'(exp_q.pop_front()));
      end
    end
    if (!reset && bus.data_valid !== 1'b1 && bus.data_out !== prev_data) spurious++;
    prev_data = bus.data_out;
    dv_prev   = bus.data_valid;
  end

  // driver tasks (all start and end on a falling edge)
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b);
  endtask

  task automatic expect_frame(input logic pe, input logic fe, input logic [7:0] d);
    exp_q.push_back({pe, fe, d});
    n_sent++;
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_data_out",   32'(bus.data_out),   0);
    check("rst_data_valid", 32'(bus.data_valid), 0);
    check("rst_frame_err",  32'(bus.frame_err),  0);
    check("rst_parity_err", 32'(bus.parity_err), 0);
    check("rst_busy",       32'(bus.busy),       0);
    check("rst_state",      32'(state),          0);
    idle(20);

    // good frame
    expect_frame(1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(OS * 2);
    check("a5_busy_after", 32'(bus.busy), 0);
    check("a5_dv_count",   dv_count,      1);
    check("a5_state_idle", 32'(state),    0);

    // false start: 4 ticks low
    c0 = dv_count;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("fs_busy_high", 32'(bus.busy), 1);
    rx = 1'b1;
    repeat (OS) @(negedge clk);
    check("fs_busy_low",  32'(bus.busy),     0);
    check("fs_no_dv",     dv_count,          c0);
    check("fs_data_hold", 32'(bus.data_out), 32'h A5);

    // bad stop bit then a good frame
    expect_frame(1'b0, 1'b1, 8'h3C);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(OS * 3);
    check("bs_frame_err", 32'(bus.frame_err), 1);
    expect_frame(1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(OS * 2);
    check("bs_fe_cleared", 32'(bus.frame_err), 0);

    // back-to-back frames
    expect_frame(1'b0, 1'b0, 8'h00);
    expect_frame(1'b0, 1'b0, 8'hFF);
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(OS * 2);
    check("b2b_spacing", last_dv_cyc - prev_dv_cyc, FRAME_BITS * OS);

    // tick on every other clock
    tick_div = 2;
    idle(8);
    expect_frame(1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(OS * 4);
    tick_div = 1;
    idle(8);

    // break: line held low long enough for exactly two frames
    expect_frame(1'b0, 1'b1, 8'h00);
    expect_frame(1'b0, 1'b1, 8'h00);
    rx = 1'b0;
    repeat (2 * F_TICKS + 7) @(negedge clk);
    idle(OS * 4);
    check("brk_busy_low",  32'(bus.busy),      0);
    check("brk_frame_err", 32'(bus.frame_err), 1);

`ifdef UART_RX_PARITY_EN
    expect_frame(1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(OS * 2);
    check("par_ok", 32'(bus.parity_err), 0);
    expect_frame(1'b1, 1'b0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(OS * 2);
    check("par_err",  32'(bus.parity_err), 1);
    check("par_data", 32'(bus.data_out),   32'h07);
`endif

    // leave nonzero outputs behind, then reset in the middle of 0x55
    expect_frame(1'b0, 1'b1, 8'hC3);
    send_frame(8'hC3, 1'b0, ^8'hC3);
    idle(OS * 3);
    c0 = dv_count;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 ^ i[0]);
    check("mid_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    check("mid_data_out",   32'(bus.data_out),   0);
    check("mid_data_valid", 32'(bus.data_valid), 0);
    check("mid_frame_err",  32'(bus.frame_err),  0);
    check("mid_parity_err", 32'(bus.parity_err), 0);
    check("mid_busy_low",   32'(bus.busy),       0);
    check("mid_state",      32'(state),          0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(OS * 2);
    check("mid_no_dv", dv_count, c0);
    expect_frame(1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(OS * 2);
    check("mid_after_data", 32'(bus.data_out), 32'h81);

    check("queue_empty",    exp_q.size(), 0);
    check("dv_total",       dv_count,     n_sent);
    check("dv_single",      dv_double,    0);
    check("data_out_hold",  spurious,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
